// File: rtl/host_cmd_frontend_pkg.sv
// Shared command layout, typedefs and sizing helpers for the host command front end.
package host_cmd_frontend_pkg;

  localparam int CMD_W        = 34;
  localparam int CMD_RW_BIT   = 31;
  localparam int CMD_BANK_LSB = 0;
  localparam int CMD_ROW_LSB  = 17;
  localparam int CMD_COL_LSB  = 3;

  typedef struct packed {
    logic [1:0]  rank;
    logic        rw;
    logic        rsvd0;
    logic [12:0] row;
    logic        rsvd1;
    logic        bl;
    logic        rsvd2;
    logic        auto_pre;
    logic [9:0]  col;
    logic [2:0]  bank;
  } cmd_t;

  // Index width for n entries, never narrower than one bit.
  function automatic int tag_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/host_cmd_frontend_fe_bank_fifo.sv
// Per-bank synchronous FIFO; storage is not reset, only pointers and occupancy.
module fe_bank_fifo
  import host_cmd_frontend_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic [W-1:0]                 i_din,
  input  logic                         i_pop,
  output logic [W-1:0]                 o_dout,
  output logic [$clog2(DEPTH+1)-1:0]   o_cnt
);
  localparam int PTR_W = tag_w(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout = r_mem[r_rd_ptr];
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/host_cmd_frontend.sv
// Host command front end: per-bank queues, round-robin issue, read reorder buffer.
// Optional build macro FE_PERF_CNT_EN adds saturating accepted-write/read counters.
module host_cmd_frontend
  import host_cmd_frontend_pkg::*;
#(
  parameter int DQ_BITS        = 16,
  parameter int NUM_BANK       = 8,
  parameter int CMD_FIFO_DEPTH = 4,
  parameter int RD_TAGS        = 8
) (
  input  logic                        clk,
  input  logic                        power_on_rst,
  input  logic [CMD_W-1:0]            command,
  input  logic                        valid,
  input  logic [DQ_BITS*8-1:0]        write_data,
  output logic [NUM_BANK-1:0]         ba_cmd_pm,
  output logic [DQ_BITS*8-1:0]        read_data,
  output logic                        read_data_valid,
  output logic                        be_valid,
  input  logic                        be_ready,
  output logic [CMD_W-1:0]            be_cmd,
  output logic [DQ_BITS*8-1:0]        be_wdata,
  output logic [tag_w(RD_TAGS)-1:0]   be_tag,
  input  logic                        be_rd_valid,
  input  logic [tag_w(RD_TAGS)-1:0]   be_rd_tag,
  input  logic [DQ_BITS*8-1:0]        be_rd_data,
  output logic [1:0]                  err_sticky,
  output logic [31:0]                 perf_wr_cnt,
  output logic [31:0]                 perf_rd_cnt
);
  localparam int TAG_W  = tag_w(RD_TAGS);
  localparam int DATA_W = DQ_BITS*8;
  localparam int BANK_W = tag_w(NUM_BANK);
  localparam int ENT_W  = TAG_W + DATA_W + CMD_W;
  localparam int CNT_W  = $clog2(CMD_FIFO_DEPTH+1);
  localparam int IF_W   = TAG_W + 1;

  logic                r_pm_en;
  logic [BANK_W-1:0]   r_rr;
  logic                r_lock;
  logic [BANK_W-1:0]   r_lock_bank;
  logic [TAG_W-1:0]    r_tail;
  logic [TAG_W-1:0]    r_head;
  logic [IF_W-1:0]     r_inflight;
  logic [RD_TAGS-1:0]  r_out;
  logic [RD_TAGS-1:0]  r_rob_vld;
  logic [DATA_W-1:0]   r_rob_data [RD_TAGS];
  logic [1:0]          r_err;
  logic                r_rdv;
  logic [DATA_W-1:0]   r_rd_data;

  logic [CNT_W-1:0]    w_cnt  [NUM_BANK];
  logic [ENT_W-1:0]    w_dout [NUM_BANK];
  logic [BANK_W-1:0]   w_bank;
  logic                w_is_rd;
  logic                w_acc;
  logic                w_acc_rd;
  logic                w_drop;
  logic [ENT_W-1:0]    w_push_ent;
  logic                w_found;
  logic [BANK_W-1:0]   w_idx;
  logic [BANK_W-1:0]   w_rr_gnt;
  logic [BANK_W-1:0]   w_gnt;
  logic                w_pop;
  logic [ENT_W-1:0]    w_head_ent;
  logic                w_ret_ok;
  logic                w_bypass;
  logic                w_rel;
  logic [DATA_W-1:0]   w_rel_data;

  // Permission is a pure decode of state so the host sees no input-to-output path.
  always_comb begin
    ba_cmd_pm = '0;
    for (int b = 0; b < NUM_BANK; b++)
      ba_cmd_pm[b] = r_pm_en && (w_cnt[b] < CNT_W'(CMD_FIFO_DEPTH)) &&
                     (r_inflight < IF_W'(RD_TAGS));
  end

  assign w_bank     = command[CMD_BANK_LSB +: BANK_W];
  assign w_is_rd    = command[CMD_RW_BIT];
  assign w_acc      = valid && ba_cmd_pm[w_bank];
  assign w_acc_rd   = w_acc && w_is_rd;
  assign w_drop     = valid && !ba_cmd_pm[w_bank];
  assign w_push_ent = {(w_is_rd ? r_tail : TAG_W'(0)), write_data, command};

  for (genvar g = 0; g < NUM_BANK; g++) begin : g_fifo
    fe_bank_fifo #(.W(ENT_W), .DEPTH(CMD_FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (power_on_rst),
      .i_push (w_acc && (w_bank == BANK_W'(g))),
      .i_din  (w_push_ent),
      .i_pop  (w_pop && (w_gnt == BANK_W'(g))),
      .o_dout (w_dout[g]),
      .o_cnt  (w_cnt[g])
    );
  end

  always_comb begin
    w_found  = 1'b0;
    w_rr_gnt = r_rr;
    w_idx    = r_rr;
    for (int i = 0; i < NUM_BANK; i++) begin
      w_idx = BANK_W'((int'(r_rr) + i) % NUM_BANK);
      if (!w_found && (w_cnt[w_idx] != '0)) begin
        w_found  = 1'b1;
        w_rr_gnt = w_idx;
      end
    end
  end

  // A stalled grant stays locked so the presented command cannot change under the back end.
  assign w_gnt      = r_lock ? r_lock_bank : w_rr_gnt;
  assign be_valid   = w_found;
  assign w_pop      = be_valid && be_ready;
  assign w_head_ent = w_dout[w_gnt];
  assign be_cmd     = be_valid ? w_head_ent[CMD_W-1:0] : '0;
  assign be_wdata   = be_valid ? w_head_ent[CMD_W +: DATA_W] : '0;
  assign be_tag     = be_valid ? w_head_ent[CMD_W+DATA_W +: TAG_W] : '0;

  // A return landing on the head tag is released straight from the return bus.
  assign w_ret_ok   = be_rd_valid && r_out[be_rd_tag] && !r_rob_vld[be_rd_tag];
  assign w_bypass   = w_ret_ok && (be_rd_tag == r_head);
  assign w_rel      = r_rob_vld[r_head] || w_bypass;
  assign w_rel_data = r_rob_vld[r_head] ? r_rob_data[r_head] : be_rd_data;

  always_ff @(posedge clk or posedge power_on_rst) begin
    if (power_on_rst) begin
      r_pm_en     <= 1'b0;
      r_rr        <= '0;
      r_lock      <= 1'b0;
      r_lock_bank <= '0;
      r_tail      <= '0;
      r_head      <= '0;
      r_inflight  <= '0;
      r_out       <= '0;
      r_rob_vld   <= '0;
      r_err       <= '0;
      r_rdv       <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_pm_en     <= 1'b1;
      r_lock      <= be_valid && !be_ready;
      r_lock_bank <= w_gnt;
      if (w_pop)
        r_rr <= (w_gnt == BANK_W'(NUM_BANK-1)) ? '0 : w_gnt + BANK_W'(1);
      if (w_acc_rd) begin
        r_out[r_tail] <= 1'b1;
        r_tail        <= r_tail + TAG_W'(1);
      end
      if (w_ret_ok && !w_bypass) r_rob_vld[be_rd_tag] <= 1'b1;
      r_rdv <= w_rel;
      if (w_rel) begin
        r_rob_vld[r_head] <= 1'b0;
        r_out[r_head]     <= 1'b0;
        r_head            <= r_head + TAG_W'(1);
        r_rd_data         <= w_rel_data;
      end
      case ({w_acc_rd, w_rel})
        2'b10:   r_inflight <= r_inflight + IF_W'(1);
        2'b01:   r_inflight <= r_inflight - IF_W'(1);
        default: r_inflight <= r_inflight;
      endcase
      if (w_drop)                   r_err[0] <= 1'b1;
      if (be_rd_valid && !w_ret_ok) r_err[1] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_ret_ok) r_rob_data[be_rd_tag] <= be_rd_data;
  end

  assign read_data       = r_rd_data;
  assign read_data_valid = r_rdv;
  assign err_sticky      = r_err;

`ifdef FE_PERF_CNT_EN
  logic [31:0] r_wr_cnt;
  logic [31:0] r_rd_cnt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge power_on_rst) begin
    if (power_on_rst) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_acc && !w_is_rd) r_wr_cnt <= sat_inc(r_wr_cnt);
      if (w_acc_rd)          r_rd_cnt <= sat_inc(r_rd_cnt);
    end
  end

  assign perf_wr_cnt = r_wr_cnt;
  assign perf_rd_cnt = r_rd_cnt;
`else
  assign perf_wr_cnt = '0;
  assign perf_rd_cnt = '0;
`endif

endmodule

// File: tb/tb_host_cmd_frontend.sv
// Scoreboard bench for host_cmd_frontend: issue and read-return queues checked by a monitor.
module tb_host_cmd_frontend;
  import host_cmd_frontend_pkg::*;

  localparam int DW = 128;
  localparam int TW = 3;
  localparam int EW = CMD_W + DW + TW;

  logic              clk = 1'b0;
  logic              power_on_rst;
  logic [CMD_W-1:0]  command;
  logic              valid;
  logic [DW-1:0]     write_data;
  logic [7:0]        ba_cmd_pm;
  logic [DW-1:0]     read_data;
  logic              read_data_valid;
  logic              be_valid;
  logic              be_ready;
  logic [CMD_W-1:0]  be_cmd;
  logic [DW-1:0]     be_wdata;
  logic [TW-1:0]     be_tag;
  logic              be_rd_valid;
  logic [TW-1:0]     be_rd_tag;
  logic [DW-1:0]     be_rd_data;
  logic [1:0]        err_sticky;
  logic [31:0]       perf_wr_cnt;
  logic [31:0]       perf_rd_cnt;

  int n_chk = 0;
  int n_err = 0;
  logic [EW-1:0] exp_be [$];
  logic [DW-1:0] exp_rd [$];
  logic [CMD_W-1:0] wcmd [4];
  logic [DW-1:0]    wdat [4];
  logic [CMD_W-1:0] rcmd [3];
  logic [CMD_W-1:0] c;

  host_cmd_frontend dut (
    .clk(clk), .power_on_rst(power_on_rst), .command(command), .valid(valid),
    .write_data(write_data), .ba_cmd_pm(ba_cmd_pm), .read_data(read_data),
    .read_data_valid(read_data_valid), .be_valid(be_valid), .be_ready(be_ready),
    .be_cmd(be_cmd), .be_wdata(be_wdata), .be_tag(be_tag), .be_rd_valid(be_rd_valid),
    .be_rd_tag(be_rd_tag), .be_rd_data(be_rd_data), .err_sticky(err_sticky),
    .perf_wr_cnt(perf_wr_cnt), .perf_rd_cnt(perf_rd_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CMD_W-1:0] mk(input logic rw, input logic [2:0] bank,
                                          input logic [12:0] row, input logic [9:0] col);
    return {2'b00, rw, 1'b0, row, 1'b0, 1'b0, 1'b0, 1'b0, col, bank};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [CMD_W-1:0] cm, input logic [DW-1:0] d);
    command = cm; write_data = d; valid = 1'b1;
    step(1);
    valid = 1'b0;
  endtask

  task automatic ret(input logic [TW-1:0] t, input logic [DW-1:0] d);
    be_rd_valid = 1'b1; be_rd_tag = t; be_rd_data = d;
    step(1);
    be_rd_valid = 1'b0;
  endtask

  task automatic drain_be();
    for (int i = 0; i < 40 && exp_be.size() != 0; i++) step(1);
    chk("be_queue_drained", 256'(exp_be.size()), 256'(0));
  endtask

  // Monitor: compares every handshake and every read strobe against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (!power_on_rst && be_valid && be_ready) begin
        if (exp_be.size() == 0) chk("be_unexpected", 256'(be_valid), 256'(0));
        else chk("be_issue", 256'({be_cmd, be_wdata, be_tag}), 256'(exp_be.pop_front()));
      end
      if (read_data_valid) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", 256'(read_data_valid), 256'(0));
        else chk("rd_data", 256'(read_data), 256'(exp_rd.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    power_on_rst = 1'b1; valid = 1'b0; command = '0; write_data = '0;
    be_ready = 1'b0; be_rd_valid = 1'b0; be_rd_tag = '0; be_rd_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pm", 256'(ba_cmd_pm), 256'(0));
    chk("rst_be_valid", 256'(be_valid), 256'(0));
    chk("rst_rdv", 256'(read_data_valid), 256'(0));
    chk("rst_err", 256'(err_sticky), 256'(0));
    power_on_rst = 1'b0;
    step(1);
    chk("post_rst_pm", 256'(ba_cmd_pm), 256'(8'hFF));

    // Fill bank 0 with the back end stalled.
    for (int i = 0; i < 4; i++) begin
      wcmd[i] = mk(1'b0, 3'd0, 13'(i + 1), 10'(i * 8));
      wdat[i] = {4{32'hA000_0000 + 32'(i)}};
      send(wcmd[i], wdat[i]);
    end
    chk("full_pm", 256'(ba_cmd_pm), 256'(8'hFE));
    send(mk(1'b0, 3'd0, 13'h1FFF, 10'h3FF), {4{32'hDEAD_BEEF}});
    chk("drop_err", 256'(err_sticky), 256'(2'b01));
    chk("drop_pm", 256'(ba_cmd_pm), 256'(8'hFE));

    rcmd[0] = mk(1'b1, 3'd3, 13'h30, 10'h13);
    rcmd[1] = mk(1'b1, 3'd1, 13'h10, 10'h11);
    rcmd[2] = mk(1'b1, 3'd6, 13'h60, 10'h16);
    for (int i = 0; i < 3; i++) send(rcmd[i], '0);
    chk("reads_pm", 256'(ba_cmd_pm), 256'(8'hFE));

    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 256'(be_valid), 256'(1));
      chk("stall_cmd", 256'({be_cmd, be_wdata, be_tag}), 256'({wcmd[0], wdat[0], 3'd0}));
      step(1);
    end

    // Locked bank 0 goes first, then round-robin 1,3,6 before bank 0 again.
    exp_be.push_back({wcmd[0], wdat[0], 3'd0});
    exp_be.push_back({rcmd[1], {DW{1'b0}}, 3'd1});
    exp_be.push_back({rcmd[0], {DW{1'b0}}, 3'd0});
    exp_be.push_back({rcmd[2], {DW{1'b0}}, 3'd2});
    for (int i = 1; i < 4; i++) exp_be.push_back({wcmd[i], wdat[i], 3'd0});
    be_ready = 1'b1;
    drain_be();
    chk("drained_be_valid", 256'(be_valid), 256'(0));

    // Out-of-order returns must come back in tag order 0,1,2.
    exp_rd.push_back({4{32'hBBBB_0000}});
    exp_rd.push_back({4{32'hCCCC_0001}});
    exp_rd.push_back({4{32'hAAAA_0002}});
    ret(3'd2, {4{32'hAAAA_0002}});
    chk("no_release_rdv", 256'(read_data_valid), 256'(0));
    ret(3'd0, {4{32'hBBBB_0000}});
    chk("rel0_rdv", 256'(read_data_valid), 256'(1));
    ret(3'd1, {4{32'hCCCC_0001}});
    chk("rel1_rdv", 256'(read_data_valid), 256'(1));
    step(1);
    chk("rel2_rdv", 256'(read_data_valid), 256'(1));
    step(1);
    chk("idle_rdv", 256'(read_data_valid), 256'(0));
    chk("hold_read_data", 256'(read_data), 256'({4{32'hAAAA_0002}}));
    chk("rd_queue_empty", 256'(exp_rd.size()), 256'(0));
    chk("rob_empty_pm", 256'(ba_cmd_pm), 256'(8'hFF));

    // Reset in the middle of queued traffic discards everything.
    be_ready = 1'b0;
    send(mk(1'b0, 3'd2, 13'h22, 10'h2), {4{32'h1234_5678}});
    send(mk(1'b1, 3'd4, 13'h44, 10'h4), '0);
    send(mk(1'b0, 3'd5, 13'h55, 10'h5), {4{32'h8765_4321}});
    chk("pre_rst_be_valid", 256'(be_valid), 256'(1));
    power_on_rst = 1'b1;
    #1;
    chk("mid_rst_be_valid", 256'(be_valid), 256'(0));
    chk("mid_rst_pm", 256'(ba_cmd_pm), 256'(0));
    chk("mid_rst_be_out", 256'({be_cmd, be_wdata, be_tag}), 256'(0));
    chk("mid_rst_err", 256'(err_sticky), 256'(0));
    chk("mid_rst_read_data", 256'({read_data_valid, read_data}), 256'(0));
    chk("mid_rst_perf", 256'({perf_wr_cnt, perf_rd_cnt}), 256'(0));
    step(2);
    power_on_rst = 1'b0;
    step(1);
    chk("after_rst_pm", 256'(ba_cmd_pm), 256'(8'hFF));
    chk("after_rst_be_valid", 256'(be_valid), 256'(0));

    // Exhaust all eight tags, then free one.
    be_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      c = mk(1'b1, 3'(i), 13'(16 * i), 10'(i));
      exp_be.push_back({c, {DW{1'b0}}, 3'(i)});
      send(c, '0);
    end
    chk("tags_full_pm", 256'(ba_cmd_pm), 256'(0));
    drain_be();
    chk("tags_full_pm_hold", 256'(ba_cmd_pm), 256'(0));
    exp_rd.push_back({4{32'hD00D_0000}});
    ret(3'd0, {4{32'hD00D_0000}});
    chk("reopen_pm", 256'(ba_cmd_pm), 256'(8'hFF));
    chk("reopen_rdv", 256'(read_data_valid), 256'(1));
    chk("good_return_err", 256'(err_sticky), 256'(2'b00));
    ret(3'd0, {4{32'hEEEE_EEEE}});
    chk("dup_return_err", 256'(err_sticky), 256'(2'b10));
    step(2);
    chk("final_rd_queue", 256'(exp_rd.size()), 256'(0));
`ifdef FE_PERF_CNT_EN
    chk("perf_wr", 256'(perf_wr_cnt), 256'(0));
    chk("perf_rd", 256'(perf_rd_cnt), 256'(8));
`else
    chk("perf_wr", 256'(perf_wr_cnt), 256'(0));
    chk("perf_rd", 256'(perf_rd_cnt), 256'(0));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
